i3c_pad_bank: RTL and testbench
===============================

Name: i3c_pad_bank

Overview:
- Multi-channel pad controller driving N_CH I3C-capable IO cells through their OUTPUT_ENABLE, D_OUT_0, D_IN_0, PU_ENB and WEAK_PU_ENB pins.
- Adds per-channel bus modes (hi-z, open-drain, push-pull) with a timed turnaround between modes.
- Adds automatic strong/weak pull-up sequencing, input synchronisation plus glitch filtering, edge strobes, and a sticky open-drain arbitration-loss flag.
- Sits between the I3C/I2C protocol engine and the pad cells.

Parameters:
- N_CH, 2, number of pad channels (>=1).
- FILT_CYCLES, 3, consecutive stable cycles required before the filtered input changes (>=1).
- TURN_CYCLES, 2, bus-released cycles inserted on every mode change (>=1).
- OD_STRONG_PU, 1, enable the strong pull-up while in open-drain mode.
- IDLE_WEAK_PU, 1, enable the weak pull-up while in hi-z mode.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous active-high reset.
- MODE  in  2*N_CH  per-channel requested mode: 00 hi-z, 01 open-drain, 10 push-pull, 11 treated as 00.
- DOUT  in  N_CH  per-channel data to drive.
- ARB_CLR  in  N_CH  per-channel clear of ARB_LOST.
- DIN  out  N_CH  filtered pad input.
- DIN_RISE  out  N_CH  1-cycle pulse on a filtered 0->1 change.
- DIN_FALL  out  N_CH  1-cycle pulse on a filtered 1->0 change.
- BUSY  out  N_CH  channel is in turnaround.
- ARB_LOST  out  N_CH  sticky: released high in open-drain but bus read low.
- PAD_OE  out  N_CH  to the cell OUTPUT_ENABLE.
- PAD_DOUT  out  N_CH  to the cell D_OUT_0.
- PAD_DIN  in  N_CH  from the cell D_IN_0 (asynchronous).
- PAD_PU_ENB  out  N_CH  strong pull-up enable, active low.
- PAD_WEAK_PU_ENB  out  N_CH  weak pull-up enable, active low.

Behaviour:
- Channels are fully independent; all registers clear on RST at the CLK edge.
- Reset values: state=HIZ, PAD_OE=0, PAD_DOUT=0, PAD_PU_ENB=1, PAD_WEAK_PU_ENB=~IDLE_WEAK_PU, DIN=all 1, DIN_RISE=DIN_FALL=0, BUSY=0, ARB_LOST=0, filter counters=0, sync flops=1.
- Per-channel FSM states: HIZ, OD, PP, TURN. cur_mode holds the last settled mode; tgt holds the pending mode.
- In HIZ, OD or PP, if MODE (decoded) != cur_mode: load tgt=MODE, load turn_cnt=TURN_CYCLES-1, go to TURN.
- In TURN: PAD_OE=0, PAD_DOUT=0, BUSY=1. Pull-ups are already those of tgt.
  - If MODE != tgt: reload tgt and turn_cnt; stay in TURN (restart).
  - Else if turn_cnt==0: go to tgt and set cur_mode=tgt.
  - Otherwise decrement turn_cnt.
- Mode request to the first driven cycle of the new mode = 1 + TURN_CYCLES cycles.
- Outputs are registered, one cycle after the state/DOUT sample:
  - HIZ: OE=0, PU_ENB=1, WEAK_PU_ENB=~IDLE_WEAK_PU.
  - OD: OE=~DOUT, PAD_DOUT=0, PU_ENB=~OD_STRONG_PU, WEAK_PU_ENB=1.
  - PP: OE=1, PAD_DOUT=DOUT, PU_ENB=1, WEAK_PU_ENB=1.
- Input path: 2-flop synchroniser on PAD_DIN, then the filter.
  - While sync==DIN: cnt=0. Otherwise cnt increments.
  - When cnt reaches FILT_CYCLES-1 with sync still !=DIN: DIN<=sync, cnt<=0, and the matching RISE/FALL pulse is asserted in the same cycle as DIN changes.
  - A pad change appears on DIN after 2+FILT_CYCLES cycles. A pulse shorter than FILT_CYCLES synced cycles produces no change.
- ARB_LOST: set when state==OD, the registered PAD_OE==0 (released), and DIN==0.
  - Cleared by ARB_CLR; set wins if set and clear coincide.
  - Not set in HIZ, PP or TURN.
- RST during TURN returns the channel to HIZ immediately with reset values; the pending tgt is discarded.

Test Plan:
1. Reset, MODE=00, PAD_DIN=1 -> PAD_OE=0, PAD_PU_ENB=1, PAD_WEAK_PU_ENB=0, DIN=1, BUSY=0 on all channels.
2. ch0 MODE 00->01 at cycle t, DOUT=0 -> BUSY=1 for cycles t+1..t+2, PAD_OE=1 and PAD_DOUT=0 from t+3, PAD_PU_ENB=0 from t+1; ch1 outputs unchanged throughout.
3. ch0 in OD, MODE->10 with DOUT=1 -> turnaround with PAD_OE=0 and PAD_PU_ENB=1, then PAD_OE=1 and PAD_DOUT=1; MODE changed to 01 during TURN -> turnaround restarts, ends in OD.
4. PAD_DIN low for 2 cycles then high (FILT_CYCLES=3) -> DIN stays 1, no pulses; PAD_DIN low for 3+ cycles -> DIN=0 exactly 5 cycles after the edge, DIN_FALL single pulse.
5. ch1 in OD, DOUT=1, PAD_DIN forced 0 -> ARB_LOST[1]=1 after the filter delay and stays set; ARB_CLR[1] pulse while still low -> remains 1; bus returns high, then ARB_CLR -> 0.
6. RST asserted mid-TURN -> next cycle all reset values, BUSY=0; MODE still 10 after reset -> fresh full turnaround to PP.

Source files
------------

// File: rtl/i3c_pad_bank_if.sv
// rtl/i3c_pad_bank_if.sv - protocol-engine and pad-cell signal bundle for i3c_pad_bank
interface i3c_pad_bank_if #(
  parameter int N_CH = 2
);
  logic [2*N_CH-1:0] MODE;
  logic [N_CH-1:0]   DOUT;
  logic [N_CH-1:0]   ARB_CLR;
  logic [N_CH-1:0]   DIN;
  logic [N_CH-1:0]   DIN_RISE;
  logic [N_CH-1:0]   DIN_FALL;
  logic [N_CH-1:0]   BUSY;
  logic [N_CH-1:0]   ARB_LOST;
  logic [N_CH-1:0]   PAD_OE;
  logic [N_CH-1:0]   PAD_DOUT;
  logic [N_CH-1:0]   PAD_DIN;
  logic [N_CH-1:0]   PAD_PU_ENB;
  logic [N_CH-1:0]   PAD_WEAK_PU_ENB;

  // Pad bank side: consumes requests and the raw pad input, produces pad controls.
  modport slave (
    input  MODE, DOUT, ARB_CLR, PAD_DIN,
    output DIN, DIN_RISE, DIN_FALL, BUSY, ARB_LOST,
    output PAD_OE, PAD_DOUT, PAD_PU_ENB, PAD_WEAK_PU_ENB
  );

  // Engine/pad side: the mirror view.
  modport master (
    output MODE, DOUT, ARB_CLR, PAD_DIN,
    input  DIN, DIN_RISE, DIN_FALL, BUSY, ARB_LOST,
    input  PAD_OE, PAD_DOUT, PAD_PU_ENB, PAD_WEAK_PU_ENB
  );
endinterface

// File: rtl/i3c_pad_bank.sv
// rtl/i3c_pad_bank.sv - per-channel I3C pad mode sequencer, input filter and arbitration monitor
module i3c_pad_bank #(
  parameter int N_CH         = 2,
  parameter int FILT_CYCLES  = 3,
  parameter int TURN_CYCLES  = 2,
  parameter int OD_STRONG_PU = 1,
  parameter int IDLE_WEAK_PU = 1
) (
  input  logic            CLK,
  input  logic            RST,
  i3c_pad_bank_if.slave   bus
);

  // Settled states share the encoding of the MODE field so a target can be
  // promoted to a state directly.
  typedef enum logic [1:0] {
    ST_HIZ  = 2'b00,
    ST_OD   = 2'b01,
    ST_PP   = 2'b10,
    ST_TURN = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HIZ = 2'b00;
  localparam logic [1:0] MODE_OD  = 2'b01;
  localparam logic [1:0] MODE_PP  = 2'b10;

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  localparam logic [TW-1:0] TURN_INIT = TW'(TURN_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);

  // Pull-up enables are active low.
  localparam logic OD_PU_ENB    = (OD_STRONG_PU != 0) ? 1'b0 : 1'b1;
  localparam logic IDLE_WPU_ENB = (IDLE_WEAK_PU != 0) ? 1'b0 : 1'b1;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [1:0]    mode_req;
    state_t        state_q, state_d;
    logic [1:0]    cur_mode_q, cur_mode_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [1:0]    eff_mode;
    logic [TW-1:0] turn_cnt_q, turn_cnt_d;
    logic          oe_q, oe_d;
    logic          pdout_q, pdout_d;
    logic          pu_enb_q, pu_enb_d;
    logic          wpu_enb_q, wpu_enb_d;
    logic          busy_q;
    logic          sync1_q, sync2_q;
    logic          din_q, rise_q, fall_q;
    logic [FW-1:0] filt_cnt_q;
    logic          arb_q;

    // The reserved encoding 11 behaves exactly like a hi-z request.
    assign mode_req = (bus.MODE[2*ch +: 2] == 2'b11) ? MODE_HIZ : bus.MODE[2*ch +: 2];

    // Mode sequencing: any change of request (even mid-turnaround) restarts a full release window.
    always_comb begin
      state_d    = state_q;
      cur_mode_d = cur_mode_q;
      tgt_d      = tgt_q;
      turn_cnt_d = turn_cnt_q;
      if (state_q == ST_TURN) begin
        if (mode_req != tgt_q) begin
          tgt_d      = mode_req;
          turn_cnt_d = TURN_INIT;
        end else if (turn_cnt_q == '0) begin
          state_d    = state_t'(tgt_q);
          cur_mode_d = tgt_q;
        end else begin
          turn_cnt_d = turn_cnt_q - TW'(1);
        end
      end else if (mode_req != cur_mode_q) begin
        tgt_d      = mode_req;
        turn_cnt_d = TURN_INIT;
        state_d    = ST_TURN;
      end
    end

    // Pad controls for the coming cycle; pull-ups follow the target early so the line is
    // already biased correctly when the new mode starts driving.
    always_comb begin
      eff_mode  = (state_d == ST_TURN) ? tgt_d : cur_mode_d;
      oe_d      = 1'b0;
      pdout_d   = 1'b0;
      pu_enb_d  = 1'b1;
      wpu_enb_d = IDLE_WPU_ENB;
      case (state_d)
        ST_OD: oe_d = ~bus.DOUT[ch];
        ST_PP: begin
          oe_d    = 1'b1;
          pdout_d = bus.DOUT[ch];
        end
        default: ;
      endcase
      case (eff_mode)
        MODE_OD: begin
          pu_enb_d  = OD_PU_ENB;
          wpu_enb_d = 1'b1;
        end
        MODE_PP: begin
          pu_enb_d  = 1'b1;
          wpu_enb_d = 1'b1;
        end
        default: begin
          pu_enb_d  = 1'b1;
          wpu_enb_d = IDLE_WPU_ENB;
        end
      endcase
    end

    // FSM state and registered pad-cell controls.
    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q    <= ST_HIZ;
        cur_mode_q <= MODE_HIZ;
        tgt_q      <= MODE_HIZ;
        turn_cnt_q <= '0;
        oe_q       <= 1'b0;
        pdout_q    <= 1'b0;
        pu_enb_q   <= 1'b1;
        wpu_enb_q  <= IDLE_WPU_ENB;
        busy_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cur_mode_q <= cur_mode_d;
        tgt_q      <= tgt_d;
        turn_cnt_q <= turn_cnt_d;
        oe_q       <= oe_d;
        pdout_q    <= pdout_d;
        pu_enb_q   <= pu_enb_d;
        wpu_enb_q  <= wpu_enb_d;
        busy_q     <= (state_d == ST_TURN);
      end
    end

    // Two-flop synchroniser, then accept a new level only after it has held for FILT_CYCLES.
    always_ff @(posedge CLK) begin
      if (RST) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        din_q      <= 1'b1;
        filt_cnt_q <= '0;
        rise_q     <= 1'b0;
        fall_q     <= 1'b0;
      end else begin
        sync1_q <= bus.PAD_DIN[ch];
        sync2_q <= sync1_q;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        if (sync2_q == din_q) begin
          filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
          din_q      <= sync2_q;
          filt_cnt_q <= '0;
          rise_q     <= sync2_q;
          fall_q     <= ~sync2_q;
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end
    end

    // Sticky arbitration loss: we released the line in open-drain yet someone holds it low.
    always_ff @(posedge CLK) begin
      if (RST) begin
        arb_q <= 1'b0;
      end else if (state_q == ST_OD && !oe_q && !din_q) begin
        arb_q <= 1'b1;
      end else if (bus.ARB_CLR[ch]) begin
        arb_q <= 1'b0;
      end
    end

    assign bus.DIN[ch]             = din_q;
    assign bus.DIN_RISE[ch]        = rise_q;
    assign bus.DIN_FALL[ch]        = fall_q;
    assign bus.BUSY[ch]            = busy_q;
    assign bus.ARB_LOST[ch]        = arb_q;
    assign bus.PAD_OE[ch]          = oe_q;
    assign bus.PAD_DOUT[ch]        = pdout_q;
    assign bus.PAD_PU_ENB[ch]      = pu_enb_q;
    assign bus.PAD_WEAK_PU_ENB[ch] = wpu_enb_q;
  end

endmodule

// File: tb/tb_i3c_pad_bank.sv
// tb/tb_i3c_pad_bank.sv - randomized self-checking bench for i3c_pad_bank
module tb_i3c_pad_bank;
  localparam int N_CH = 2;
  localparam int FILT = 3;
  localparam int TURN = 2;
  localparam int ODPU = 1;
  localparam int IWPU = 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  i3c_pad_bank_if #(.N_CH(N_CH)) bus();

  i3c_pad_bank #(
    .N_CH(N_CH), .FILT_CYCLES(FILT), .TURN_CYCLES(TURN),
    .OD_STRONG_PU(ODPU), .IDLE_WEAK_PU(IWPU)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: request history and pad-sample history per channel.
  // A channel is settled when its last TURN+1 requests agree; the filtered
  // input flips when the last FILT synchronised samples all disagree with it.
  int mh [N_CH][TURN+1];
  int ph [N_CH][FILT+1];
  int m_state [N_CH];
  logic [N_CH-1:0] m_din, m_rise, m_fall, m_busy, m_arb, m_oe, m_pdout, m_pu, m_wpu;

  task automatic check_eq(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (RST) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k <= TURN; k++) mh[c][k] = 0;
        for (int k = 0; k <= FILT; k++) ph[c][k] = 1;
        m_state[c] = 0;
      end
      m_din = '1; m_rise = '0; m_fall = '0; m_busy = '0; m_arb = '0;
      m_oe = '0; m_pdout = '0; m_pu = '1;
      m_wpu = (IWPU != 0) ? '0 : '1;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        int  req;
        bit  settled;
        bit  all_diff;
        if (m_state[c] == 1 && !m_oe[c] && !m_din[c]) m_arb[c] = 1'b1;
        else if (bus.ARB_CLR[c]) m_arb[c] = 1'b0;

        all_diff = 1'b1;
        for (int k = 1; k <= FILT; k++) if (ph[c][k] == int'(m_din[c])) all_diff = 1'b0;
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (all_diff) begin
          m_din[c]  = ~m_din[c];
          m_rise[c] = m_din[c];
          m_fall[c] = ~m_din[c];
        end
        for (int k = FILT; k > 0; k--) ph[c][k] = ph[c][k-1];
        ph[c][0] = int'(bus.PAD_DIN[c]);

        req = int'(bus.MODE[2*c +: 2]);
        if (req == 3) req = 0;
        for (int k = TURN; k > 0; k--) mh[c][k] = mh[c][k-1];
        mh[c][0] = req;
        settled = 1'b1;
        for (int k = 0; k <= TURN; k++) if (mh[c][k] != req) settled = 1'b0;
        m_state[c] = settled ? req : 3;
        m_busy[c]  = !settled;

        case (req)
          1:       begin m_pu[c] = (ODPU != 0) ? 1'b0 : 1'b1; m_wpu[c] = 1'b1; end
          2:       begin m_pu[c] = 1'b1; m_wpu[c] = 1'b1; end
          default: begin m_pu[c] = 1'b1; m_wpu[c] = (IWPU != 0) ? 1'b0 : 1'b1; end
        endcase
        m_oe[c]    = (m_state[c] == 1) ? ~bus.DOUT[c] : (m_state[c] == 2);
        m_pdout[c] = (m_state[c] == 2) && bus.DOUT[c];
      end
    end
  endtask

  task automatic compare_all();
    check_eq("DIN",      bus.DIN,             m_din);
    check_eq("DIN_RISE", bus.DIN_RISE,        m_rise);
    check_eq("DIN_FALL", bus.DIN_FALL,        m_fall);
    check_eq("BUSY",     bus.BUSY,            m_busy);
    check_eq("ARB_LOST", bus.ARB_LOST,        m_arb);
    check_eq("PAD_OE",   bus.PAD_OE,          m_oe);
    check_eq("PAD_DOUT", bus.PAD_DOUT,        m_pdout);
    check_eq("PU_ENB",   bus.PAD_PU_ENB,      m_pu);
    check_eq("WPU_ENB",  bus.PAD_WEAK_PU_ENB, m_wpu);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      #1;
      cyc++;
      compare_all();
    end
  endtask

  task automatic set_mode(input int c, input logic [1:0] v);
    bus.MODE[2*c +: 2] = v;
  endtask

  int hold [N_CH];

  initial begin
    bus.MODE    = '0;
    bus.DOUT    = '0;
    bus.ARB_CLR = '0;
    bus.PAD_DIN = '1;
    RST = 1'b1;
    step(2);
    check_eq("rst_oe",   bus.PAD_OE,          '0);
    check_eq("rst_pu",   bus.PAD_PU_ENB,      '1);
    check_eq("rst_wpu",  bus.PAD_WEAK_PU_ENB, '0);
    check_eq("rst_din",  bus.DIN,             '1);
    check_eq("rst_busy", bus.BUSY,            '0);
    RST = 1'b0;
    step(2);

    // ch0 hi-z -> open-drain with DOUT=0
    set_mode(0, 2'b01);
    step(6);
    // ch0 open-drain -> push-pull, then redirected back to open-drain mid-turnaround
    bus.DOUT[0] = 1'b1;
    set_mode(0, 2'b10);
    step(6);
    set_mode(0, 2'b01);
    step(1);
    set_mode(0, 2'b10);
    step(1);
    set_mode(0, 2'b01);
    step(6);

    // ch0 glitch of two cycles, then a real low level
    bus.PAD_DIN[0] = 1'b0; step(2);
    bus.PAD_DIN[0] = 1'b1; step(6);
    bus.PAD_DIN[0] = 1'b0; step(8);
    bus.PAD_DIN[0] = 1'b1; step(8);

    // ch1 arbitration loss in open-drain
    set_mode(1, 2'b01);
    bus.DOUT[1] = 1'b1;
    step(5);
    bus.PAD_DIN[1] = 1'b0; step(10);
    bus.ARB_CLR[1] = 1'b1; step(1);
    bus.ARB_CLR[1] = 1'b0; step(3);
    bus.PAD_DIN[1] = 1'b1; step(7);
    bus.ARB_CLR[1] = 1'b1; step(1);
    bus.ARB_CLR[1] = 1'b0; step(3);

    // reset in the middle of a turnaround, request held through reset
    set_mode(0, 2'b10);
    step(1);
    RST = 1'b1; step(1);
    check_eq("rst_mid_busy", bus.BUSY, '0);
    RST = 1'b0; step(6);

    // randomized traffic
    for (int c = 0; c < N_CH; c++) hold[c] = 0;
    for (int r = 0; r < 4000; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 19) == 0) set_mode(c, 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) bus.DOUT[c] = ~bus.DOUT[c];
        if (hold[c] == 0) begin
          bus.PAD_DIN[c] = ~bus.PAD_DIN[c];
          hold[c] = $urandom_range(1, 7);
        end else begin
          hold[c]--;
        end
        bus.ARB_CLR[c] = ($urandom_range(0, 15) == 0);
      end
      RST = ($urandom_range(0, 499) == 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
